// File: rtl/gdsp_pkg.sv
// Shared DSP types and constants for the symbol-rate receive chain.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package gdsp_pkg;

    typedef logic signed [11:0] sample_t;
    typedef logic signed [12:0] err_t;
    typedef logic        [15:0] gain_t;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    // 16-QAM grid: levels at +/-QAM_UNIT and +/-3*QAM_UNIT, decisions at 0 and +/-2*QAM_UNIT
    localparam sample_t QAM_UNIT   = 12'sd384;
    localparam sample_t QAM_LVL3   = 12'sd1152;
    localparam sample_t QAM_THR_HI = 12'sd768;
    localparam sample_t QAM_THR_LO = -12'sd768;

    // EVM block is 2^EVM_LEN_LOG2 symbols
    localparam int EVM_LEN_LOG2 = 8;

    // Level index 0..3 (-3,-1,+1,+3) to Gray bits 00,01,11,10
    function automatic logic [1:0] qam16_gray(input logic [1:0] idx);
        return idx ^ {1'b0, idx[1]};
    endfunction

endpackage

// File: rtl/qam16_axis_slicer.sv
// Per-axis 16-QAM slicer: nearest of +/-1, +/-3 levels, Gray bits and decision error.
// Latency: purely combinational.
// Backpressure: none; output follows input.
module qam16_axis_slicer
    import gdsp_pkg::*;
(
    input  sample_t    y,
    output sample_t    level,
    output logic [1:0] bits,
    output err_t       err
);

    logic [1:0] idx;

    // Threshold compare, level lookup and error against the chosen level
    always_comb begin
        idx = 2'd0;
        if (y < QAM_THR_LO) begin
            idx = 2'd0;
        end else if (y < 12'sd0) begin
            idx = 2'd1;
        end else if (y < QAM_THR_HI) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end

        case (idx)
            2'd0:    level = -QAM_LVL3;
            2'd1:    level = -QAM_UNIT;
            2'd2:    level = QAM_UNIT;
            default: level = QAM_LVL3;
        endcase

        bits = qam16_gray(idx);
        err  = err_t'(y) - err_t'(level);
    end

endmodule

// File: rtl/qam16_slicer_agc.sv
// 16-QAM decision stage: gain scaling, slicing, decision-directed AGC, lock FSM; EVM when QAM_EVM_EN is defined.
// Latency: out_valid 2 clocks after sym_strobe; agc_gain/lock update the cycle after out_valid.
// Backpressure: none; accepts a strobe every clock, sync_clr drops any in-flight symbol.
module qam16_slicer_agc
    import gdsp_pkg::*;
#(
    parameter gain_t       GAIN_INIT     = 16'd4096,
    parameter gain_t       GAIN_MIN      = 16'd1024,
    parameter gain_t       GAIN_MAX      = 16'd32767,
    parameter int unsigned AGC_SHIFT_ACQ = 6,
    parameter int unsigned AGC_SHIFT_TRK = 10,
    parameter logic [11:0] LOCK_TOL      = 12'd128,
    parameter logic [7:0]  LOCK_CNT      = 8'd64,
    parameter logic [7:0]  UNLOCK_CNT    = 8'd16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sync_clr,
    input  sample_t     sym_I,
    input  sample_t     sym_Q,
    input  logic        sym_strobe,
    output logic [3:0]  sym_bits,
    output sample_t     dec_I,
    output sample_t     dec_Q,
    output logic        out_valid,
    output logic [15:0] agc_gain,
    output logic        lock,
    output logic [31:0] evm_acc,
    output logic        evm_valid
);

    // Q1.11 sample times Q4.12 gain, back to Q1.11 with saturation
    function automatic sample_t scale_sat(input sample_t x, input gain_t g);
        logic signed [28:0] p;
        p = x * $signed({1'b0, g});
        p = p >>> 12;
        if (p > 29'sd2047) begin
            return 12'sd2047;
        end else if (p < -29'sd2048) begin
            return -12'sd2048;
        end else begin
            return p[11:0];
        end
    endfunction

    logic        s1_vld;
    sample_t     y_i, y_q;
    sample_t     lvl_i, lvl_q;
    logic [1:0]  bits_i, bits_q;
    err_t        err_i, err_q;
    err_t        err_i_r, err_q_r;

    lock_state_t state, state_nxt;
    logic [7:0]  good_cnt, good_nxt, bad_cnt, bad_nxt;
    gain_t       gain_nxt;

    logic signed [13:0] ei, eq, agc_e, delta;
    logic        [13:0] agc_mag, mag_sh;
    logic signed [17:0] gain_wide;
    int unsigned        shamt;
    logic        [12:0] mag_i, mag_q;
    logic               good;

    // Stage 1: scale the strobed sample with the gain currently in the register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            y_i    <= '0;
            y_q    <= '0;
        end else if (sync_clr) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= sym_strobe;
            if (sym_strobe) begin
                y_i <= scale_sat(sym_I, agc_gain);
                y_q <= scale_sat(sym_Q, agc_gain);
            end
        end
    end

    qam16_axis_slicer u_slice_i (
        .y     (y_i),
        .level (lvl_i),
        .bits  (bits_i),
        .err   (err_i)
    );

    qam16_axis_slicer u_slice_q (
        .y     (y_q),
        .level (lvl_q),
        .bits  (bits_q),
        .err   (err_q)
    );

    // Stage 2: register decisions; errors are held for the loop update that follows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sym_bits  <= '0;
            dec_I     <= '0;
            dec_Q     <= '0;
            err_i_r   <= '0;
            err_q_r   <= '0;
        end else if (sync_clr) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                sym_bits <= {bits_i, bits_q};
                dec_I    <= lvl_i;
                dec_Q    <= lvl_q;
                err_i_r  <= err_i;
                err_q_r  <= err_q;
            end
        end
    end

    // AGC error projected on the decision sign, shifted toward zero and clamped
    always_comb begin
        ei = 14'(err_i_r);
        eq = 14'(err_q_r);
        if (dec_I[11]) ei = -ei;
        if (dec_Q[11]) eq = -eq;
        agc_e = ei + eq;

        shamt   = (state == LOCKED) ? AGC_SHIFT_TRK : AGC_SHIFT_ACQ;
        agc_mag = agc_e[13] ? $unsigned(-agc_e) : $unsigned(agc_e);
        mag_sh  = agc_mag >> shamt;
        delta   = agc_e[13] ? -$signed(mag_sh) : $signed(mag_sh);

        gain_wide = $signed({2'b00, agc_gain}) - 18'(delta);
        gain_nxt  = agc_gain;
        if (out_valid) begin
            if (gain_wide < $signed({2'b00, GAIN_MIN})) begin
                gain_nxt = GAIN_MIN;
            end else if (gain_wide > $signed({2'b00, GAIN_MAX})) begin
                gain_nxt = GAIN_MAX;
            end else begin
                gain_nxt = gain_wide[15:0];
            end
        end
    end

    // Lock FSM next state: consecutive-good count to lock, net-bad count to unlock
    always_comb begin
        mag_i     = err_i_r[12] ? $unsigned(-err_i_r) : $unsigned(err_i_r);
        mag_q     = err_q_r[12] ? $unsigned(-err_q_r) : $unsigned(err_q_r);
        good      = (mag_i <= {1'b0, LOCK_TOL}) && (mag_q <= {1'b0, LOCK_TOL});
        state_nxt = state;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        if (out_valid) begin
            case (state)
                SEARCH: begin
                    if (!good) begin
                        good_nxt = '0;
                    end else if (good_cnt + 8'd1 == LOCK_CNT) begin
                        state_nxt = LOCKED;
                        good_nxt  = '0;
                        bad_nxt   = '0;
                    end else begin
                        good_nxt = good_cnt + 8'd1;
                    end
                end
                default: begin
                    if (good) begin
                        if (bad_cnt != 8'd0) bad_nxt = bad_cnt - 8'd1;
                    end else if (bad_cnt + 8'd1 == UNLOCK_CNT) begin
                        state_nxt = SEARCH;
                        good_nxt  = '0;
                        bad_nxt   = '0;
                    end else begin
                        bad_nxt = bad_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

    // Gain and FSM registers; soft clear restores the acquisition starting point
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SEARCH;
            good_cnt <= '0;
            bad_cnt  <= '0;
            agc_gain <= GAIN_INIT;
        end else if (sync_clr) begin
            state    <= SEARCH;
            good_cnt <= '0;
            bad_cnt  <= '0;
            agc_gain <= GAIN_INIT;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
            bad_cnt  <= bad_nxt;
            agc_gain <= gain_nxt;
        end
    end

    assign lock = (state == LOCKED);

`ifdef QAM_EVM_EN
    logic [EVM_LEN_LOG2-1:0] evm_cnt;
    logic [31:0]             evm_run, evm_sum;
    logic [25:0]             sq_i, sq_q;

    // Squared decision error of the symbol entering stage 2
    always_comb begin
        sq_i    = $unsigned(26'(err_i) * 26'(err_i));
        sq_q    = $unsigned(26'(err_q) * 26'(err_q));
        evm_sum = evm_run + 32'(sq_i) + 32'(sq_q);
    end

    // Block accumulator; publishes alongside the block's last out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evm_cnt   <= '0;
            evm_run   <= '0;
            evm_acc   <= '0;
            evm_valid <= 1'b0;
        end else if (sync_clr) begin
            evm_cnt   <= '0;
            evm_run   <= '0;
            evm_acc   <= '0;
            evm_valid <= 1'b0;
        end else begin
            evm_valid <= 1'b0;
            if (s1_vld) begin
                evm_cnt <= evm_cnt + EVM_LEN_LOG2'(1);
                if (&evm_cnt) begin
                    evm_acc   <= evm_sum;
                    evm_valid <= 1'b1;
                    evm_run   <= '0;
                end else begin
                    evm_run <= evm_sum;
                end
            end
        end
    end
`else
    assign evm_acc   = '0;
    assign evm_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qam16_slicer_agc.sv
// Directed bench for qam16_slicer_agc: reset, slicing, AGC steps, lock FSM, clear, EVM.
// Latency: checks out_valid at 2 clocks after strobe, gain/lock one clock later.
// Backpressure: none; strobes driven back-to-back or isolated.
module tb_qam16_slicer_agc;
    import gdsp_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sync_clr;
    sample_t     sym_I, sym_Q;
    logic        sym_strobe;
    logic [3:0]  sym_bits;
    sample_t     dec_I, dec_Q;
    logic        out_valid;
    logic [15:0] agc_gain;
    logic        lock;
    logic [31:0] evm_acc;
    logic        evm_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    qam16_slicer_agc dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sync_clr   (sync_clr),
        .sym_I      (sym_I),
        .sym_Q      (sym_Q),
        .sym_strobe (sym_strobe),
        .sym_bits   (sym_bits),
        .dec_I      (dec_I),
        .dec_Q      (dec_Q),
        .out_valid  (out_valid),
        .agc_gain   (agc_gain),
        .lock       (lock),
        .evm_acc    (evm_acc),
        .evm_valid  (evm_valid)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int i, input int q);
        sym_I      = sample_t'(i);
        sym_Q      = sample_t'(q);
        sym_strobe = 1'b1;
        tick();
        sym_strobe = 1'b0;
    endtask

    task automatic clr();
        sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
    endtask

    initial begin
        int   bx [5];
        int   bb [5];
        int   bd [5];
        logic seen;

        bx = '{767, 768, 0, -768, -769};
        bb = '{3, 2, 3, 1, 0};
        bd = '{384, 1152, 384, -384, -1152};

        rst_n      = 1'b0;
        sync_clr   = 1'b0;
        sym_strobe = 1'b0;
        sym_I      = '0;
        sym_Q      = '0;
        repeat (3) tick();
        chk("rst_gain", agc_gain, 4096);
        chk("rst_lock", lock, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_bits", sym_bits, 0);
        chk("rst_decI", dec_I, 0);
        chk("rst_evm", evm_acc, 0);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (6) begin
            tick();
            seen |= out_valid;
        end
        chk("idle_no_valid", seen, 0);
        chk("idle_gain", agc_gain, 4096);

        // Ideal point, latency of exactly two clocks
        strobe(1152, -384);
        chk("ideal_lat1", out_valid, 0);
        tick();
        chk("ideal_valid", out_valid, 1);
        chk("ideal_bits", sym_bits, 4'b1001);
        chk("ideal_decI", dec_I, 1152);
        chk("ideal_decQ", dec_Q, -384);
        tick();
        chk("ideal_pulse", out_valid, 0);
        chk("ideal_gain", agc_gain, 4096);
        chk("ideal_held_bits", sym_bits, 4'b1001);

        // I-axis thresholds, each from a freshly cleared gain
        for (int k = 0; k < 5; k++) begin
            clr();
            strobe(bx[k], 384);
            tick();
            chk($sformatf("thr_valid_%0d", bx[k]), out_valid, 1);
            chk($sformatf("thr_bits_%0d", bx[k]), sym_bits, {bb[k][1:0], 2'b11});
            chk($sformatf("thr_dec_%0d", bx[k]), dec_I, bd[k]);
        end

        // Strobe coinciding with the gain update still sees the old gain
        clr();
        strobe(767, 384);
        tick();
        strobe(768, 384);
        chk("overlap_gainA", agc_gain, 4091);
        tick();
        chk("overlap_bitsB", sym_bits, 4'b1011);
        chk("overlap_decB", dec_I, 1152);

        // AGC step sizes
        clr();
        strobe(192, 192);
        tick();
        chk("agc_up_bits", sym_bits, 4'b1111);
        chk("agc_up_decI", dec_I, 384);
        tick();
        chk("agc_up_gain", agc_gain, 4102);
        strobe(1344, -576);
        tick();
        chk("agc_dn_bits", sym_bits, 4'b1001);
        chk("agc_dn_decQ", dec_Q, -384);
        tick();
        chk("agc_dn_gain", agc_gain, 4096);
        clr();
        strobe(284, 384);
        tick();
        tick();
        chk("agc_trunc_gain", agc_gain, 4097);

        // Lock acquisition after 64 consecutive good symbols
        clr();
        repeat (63) strobe(1152, -384);
        repeat (3) tick();
        chk("acq_63_lock", lock, 0);
        strobe(1152, -384);
        tick();
        chk("acq_64_lock_same", lock, 0);
        tick();
        chk("acq_64_lock", lock, 1);
        chk("acq_gain", agc_gain, 4096);

        // Lock loss after 16 zero-amplitude symbols
        repeat (15) strobe(0, 0);
        repeat (3) tick();
        chk("loss_15_lock", lock, 1);
        chk("loss_15_gain", agc_gain, 4096);
        strobe(0, 0);
        tick();
        chk("zero_bits", sym_bits, 4'b1111);
        chk("zero_decQ", dec_Q, 384);
        tick();
        chk("loss_16_lock", lock, 0);
        chk("loss_16_gain", agc_gain, 4096);
        strobe(0, 0);
        tick();
        tick();
        chk("search_step_gain", agc_gain, 4108);
        repeat (2400) strobe(0, 0);
        repeat (3) tick();
        chk("clamp_gain", agc_gain, 32767);

        // Input saturation at maximum gain
        strobe(2047, -2048);
        tick();
        chk("sat_bits", sym_bits, 4'b1000);
        chk("sat_decI", dec_I, 1152);
        chk("sat_decQ", dec_Q, -1152);
        tick();
        chk("sat_gain", agc_gain, 32740);

        // Clear wins over a simultaneous strobe
        sym_I      = 12'sd1152;
        sym_Q      = -12'sd384;
        sym_strobe = 1'b1;
        sync_clr   = 1'b1;
        tick();
        sym_strobe = 1'b0;
        sync_clr   = 1'b0;
        seen       = 1'b0;
        repeat (4) begin
            seen |= out_valid;
            tick();
        end
        chk("clr_no_valid", seen, 0);
        chk("clr_gain", agc_gain, 4096);
        chk("clr_lock", lock, 0);

        // Reset mid-flight discards the symbol
        strobe(192, 192);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (3) begin
            tick();
            seen |= out_valid;
        end
        chk("rst_flight_no_valid", seen, 0);
        chk("rst_flight_gain", agc_gain, 4096);

`ifdef QAM_EVM_EN
        // Constant +16 I error over a 256-symbol block
        clr();
        repeat (255) strobe(1168, -384);
        repeat (3) tick();
        chk("evm_255_valid", evm_valid, 0);
        chk("evm_255_acc", evm_acc, 0);
        strobe(1168, -384);
        tick();
        chk("evm_last_outv", out_valid, 1);
        chk("evm_valid", evm_valid, 1);
        chk("evm_acc", evm_acc, 65536);
        tick();
        chk("evm_pulse", evm_valid, 0);
`else
        clr();
        repeat (300) strobe(1168, -384);
        repeat (3) tick();
        chk("evm_off_acc", evm_acc, 0);
        chk("evm_off_valid", evm_valid, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
